// File: rtl/alu_logic_pipe_rv32i_pkg.sv
// Shared op codes, pipeline occupancy states and op legality for the RV32I logic pipe.
// ALU_LOGIC_ZBB_EN enables the negated Zbb forms (XNOR/ORN/ANDN).
package alu_logic_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_XOR  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b100;
    localparam logic [OP_W-1:0] OP_ORN  = 3'b101;
    localparam logic [OP_W-1:0] OP_ANDN = 3'b110;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_e;

    // Codes 011/111 are always reserved; the Zbb codes only exist when enabled.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_XOR, OP_OR, OP_AND: legal = 1'b1;
`ifdef ALU_LOGIC_ZBB_EN
            OP_XNOR, OP_ORN, OP_ANDN: legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_logic_pipe_rv32i_if.sv
// Input and output beat channels of the logic pipe; master is the producer/consumer side.
interface alu_logic_pipe_rv32i_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    import alu_logic_pkg::*;

    // Handshake: a beat moves on a rising edge where valid && ready; valid and its
    // payload hold until that edge, and valid never waits on ready.
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic             out_zero;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_illegal, out_tag
    );

endinterface

// File: rtl/alu_logic_pipe_rv32i_slice.sv
// One valid/ready register stage: valid follows valid_d when enabled, payload only on a real beat.
module alu_pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         valid_d,
    input  logic [W-1:0] data_d,
    output logic         valid_q,
    output logic [W-1:0] data_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en) begin
            valid_q <= valid_d;
            if (valid_d) begin
                data_q <= data_d;
            end
        end
    end

endmodule

// File: rtl/alu_logic_pipe_rv32i.sv
// Two-stage valid/ready XOR/OR/AND unit with zero and illegal-op flags.
// Define ALU_LOGIC_ZBB_EN to add XNOR/ORN/ANDN; otherwise those codes are reserved.
module alu_logic_pipe_rv32i
    import alu_logic_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_logic_pipe_rv32i_if.slave   bus,
    output pipe_state_e             pipe_state
);

    localparam int S1_W = OP_W + 2 * XLEN + TAG_W;
    localparam int S2_W = 2 + XLEN + TAG_W;

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    logic [S1_W-1:0]  s1_q;
    logic [S2_W-1:0]  s2_d;
    logic [S2_W-1:0]  s2_q;
    logic [OP_W-1:0]  s1_op;
    logic [XLEN-1:0]  s1_a;
    logic [XLEN-1:0]  s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic [XLEN-1:0]  res;
    logic             res_zero;
    logic             res_illegal;

    // in_ready looks through to out_ready so a full pipe can accept while it drains.
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = s1_valid && s2_adv;
    assign bus.in_ready = !rst && (!s1_valid || s2_adv);

    alu_pipe_slice #(.W(S1_W)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.in_ready),
        .valid_d (bus.in_valid),
        .data_d  ({bus.in_op, bus.in_a, bus.in_b, bus.in_tag}),
        .valid_q (s1_valid),
        .data_q  (s1_q)
    );

    assign {s1_op, s1_a, s1_b, s1_tag} = s1_q;

    always_comb begin
        res = '0;
        case (s1_op)
            OP_XOR:  res = s1_a ^ s1_b;
            OP_OR:   res = s1_a | s1_b;
            OP_AND:  res = s1_a & s1_b;
`ifdef ALU_LOGIC_ZBB_EN
            OP_XNOR: res = ~(s1_a ^ s1_b);
            OP_ORN:  res = s1_a | ~s1_b;
            OP_ANDN: res = s1_a & ~s1_b;
`endif
            default: res = '0;
        endcase
        res_illegal = !is_legal_op(s1_op);
        res_zero    = (res == '0);
    end

    assign s2_d = {res_illegal, res_zero, s1_tag, res};

    alu_pipe_slice #(.W(S2_W)) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .en      (s2_adv),
        .valid_d (s1_adv),
        .data_d  (s2_d),
        .valid_q (s2_valid),
        .data_q  (s2_q)
    );

    assign bus.out_valid = s2_valid;
    assign {bus.out_illegal, bus.out_zero, bus.out_tag, bus.out_data} = s2_q;

    always_comb begin
        pipe_state = PIPE_ONE;
        case ({s1_valid, s2_valid})
            2'b00:   pipe_state = PIPE_EMPTY;
            2'b11:   pipe_state = PIPE_FULL;
            default: pipe_state = PIPE_ONE;
        endcase
    end

endmodule

// File: tb/tb_alu_logic_pipe_rv32i.sv
// Scoreboard bench for alu_logic_pipe_rv32i: directed vectors, backpressure, random handshakes, mid-flight reset.
module tb_alu_logic_pipe_rv32i;
    import alu_logic_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int EW    = 2 + TAG_W + XLEN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    pipe_state_e pipe_state;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          rand_rdy = 1'b0;

    // Expected beat = {illegal, zero, tag, data}; lat_q holds the accept cycle or -1.
    logic [EW-1:0] exp_q[$];
    int            lat_q[$];

    logic [EW-1:0] mon_got;
    logic [EW-1:0] mon_exp;
    int            mon_lat;

    logic [2:0]      bp_op[4] = '{3'b001, 3'b010, 3'b000, 3'b001};
    logic [XLEN-1:0] bp_a[4]  = '{32'h1111_0000, 32'hFFFF_00FF, 32'h1234_5678, 32'hA000_0000};
    logic [XLEN-1:0] bp_b[4]  = '{32'h0000_2222, 32'h0F0F_0F0F, 32'h1234_5678, 32'h0000_000B};
    logic [XLEN-1:0] bp_d[4]  = '{32'h1111_2222, 32'h0F0F_000F, 32'h0000_0000, 32'hA000_000B};

    alu_logic_pipe_rv32i_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    alu_logic_pipe_rv32i #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .pipe_state (pipe_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack_exp(input logic ill, input logic [XLEN-1:0] d,
                                               input logic [TAG_W-1:0] tag);
        return {ill, (d == '0), tag, d};
    endfunction

    function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
        logic [XLEN-1:0] d;
        logic            ill;
        d   = '0;
        ill = 1'b0;
        case (op)
            3'b000: d = a ^ b;
            3'b001: d = a | b;
            3'b010: d = a & b;
`ifdef ALU_LOGIC_ZBB_EN
            3'b100: d = ~(a ^ b);
            3'b101: d = a | ~b;
            3'b110: d = a & ~b;
`endif
            default: ill = 1'b1;
        endcase
        return pack_exp(ill, d, tag);
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge after acceptance with in_valid still high.
    task automatic send(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAG_W-1:0] tag, input logic [EW-1:0] e, input bit lat);
        int waited;
        bit acc;
        waited = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        while (!acc) begin
            #2;
            if (bus.in_ready) begin
                exp_q.push_back(e);
                lat_q.push_back(lat ? cyc : -1);
                acc = 1'b1;
            end
            @(negedge clk);
            if (!acc) begin
                waited++;
                if (waited > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: in_ready low for %0d cycles, tag %0d", waited, tag);
                    break;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tagname);
        chk({tagname, "_in_ready"},    bus.in_ready, 0);
        chk({tagname, "_out_valid"},   bus.out_valid, 0);
        chk({tagname, "_out_data"},    bus.out_data, 0);
        chk({tagname, "_out_zero"},    bus.out_zero, 0);
        chk({tagname, "_out_illegal"}, bus.out_illegal, 0);
        chk({tagname, "_out_tag"},     bus.out_tag, 0);
        chk({tagname, "_state"},       64'(pipe_state), 64'(PIPE_EMPTY));
    endtask

    always @(negedge clk) begin
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- monitor / scoreboard ----------------
    always begin
        @(negedge clk);
        #3;
        if (!rst && bus.out_valid && bus.out_ready) begin
            mon_got = {bus.out_illegal, bus.out_zero, bus.out_tag, bus.out_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got 0x%0h with nothing expected", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_lat = lat_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL out_beat: got 0x%0h expected 0x%0h", mon_got, mon_exp);
                end
                if (mon_lat >= 0) begin
                    checks++;
                    if (cyc != mon_lat + 2) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles expected 2", cyc - mon_lat);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [EW-1:0] e_xnor, e_andn, e_orn;
        logic [2:0]    rop;
        logic [XLEN-1:0] ra, rb;
        logic [TAG_W-1:0] rtag;
        int idx;

`ifdef ALU_LOGIC_ZBB_EN
        e_xnor = pack_exp(1'b0, 32'hFFFF_FFFF, 5'd4);
        e_andn = pack_exp(1'b0, 32'h00FF_0000, 5'd5);
        e_orn  = pack_exp(1'b0, 32'h0000_0000, 5'd6);
`else
        e_xnor = pack_exp(1'b1, 32'h0, 5'd4);
        e_andn = pack_exp(1'b1, 32'h0, 5'd5);
        e_orn  = pack_exp(1'b1, 32'h0, 5'd6);
`endif

        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", bus.in_ready, 1);
        @(negedge clk);

        // Back-to-back legacy ops, latency checked.
        send(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd1, pack_exp(1'b0, 32'h0FF0_0FF0, 5'd1), 1'b1);
        send(3'b001, 32'h0000_000F, 32'h0000_00F0, 5'd2, pack_exp(1'b0, 32'h0000_00FF, 5'd2), 1'b1);
        send(3'b010, 32'h1234_5678, 32'h0F0F_0F0F, 5'd3, pack_exp(1'b0, 32'h0204_0608, 5'd3), 1'b1);
        // Zbb forms (reserved when the feature is compiled out) and reserved codes.
        send(3'b100, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 5'd4, e_xnor, 1'b1);
        send(3'b110, 32'hFFFF_0000, 32'hFF00_FF00, 5'd5, e_andn, 1'b1);
        send(3'b101, 32'h0000_0000, 32'hFFFF_FFFF, 5'd6, e_orn, 1'b1);
        send(3'b011, 32'h1234_5678, 32'h8765_4321, 5'd7, pack_exp(1'b1, 32'h0, 5'd7), 1'b1);
        send(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd9, pack_exp(1'b1, 32'h0, 5'd9), 1'b1);
        drain();

        // Backpressure: two beats fill the pipe, the rest wait.
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = bp_op[idx];
            bus.in_a     = bp_a[idx];
            bus.in_b     = bp_b[idx];
            bus.in_tag   = TAG_W'(idx + 16);
            #2;
            chk($sformatf("bp_in_ready_c%0d", c), bus.in_ready, (c < 2));
            if (bus.in_ready) begin
                exp_q.push_back(pack_exp(1'b0, bp_d[idx], TAG_W'(idx + 16)));
                lat_q.push_back(-1);
                idx++;
            end
            if (c >= 2) begin
                chk($sformatf("bp_out_valid_c%0d", c), bus.out_valid, 1);
                chk($sformatf("bp_out_data_c%0d", c), bus.out_data, bp_d[0]);
                chk($sformatf("bp_out_tag_c%0d", c), bus.out_tag, 16);
                chk($sformatf("bp_state_c%0d", c), 64'(pipe_state), 64'(PIPE_FULL));
            end
            @(negedge clk);
        end
        chk("bp_accepted", idx, 2);
        bus.out_ready = 1'b1;
        for (int i = 2; i < 4; i++)
            send(bp_op[i], bp_a[i], bp_b[i], TAG_W'(i + 16), pack_exp(1'b0, bp_d[i], TAG_W'(i + 16)), 1'b0);
        drain();

        // Random handshake stream through the reference model.
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            rop  = 3'($urandom_range(0, 7));
            ra   = $urandom;
            rb   = (n % 16 == 0) ? ra : $urandom;
            rtag = TAG_W'($urandom_range(0, 31));
            send(rop, ra, rb, rtag, model(rop, ra, rb, rtag), 1'b0);
        end
        drain();

        // Reset with two beats in flight: both are discarded.
        bus.out_ready = 1'b0;
        send(3'b001, 32'h0000_0001, 32'h0000_0002, 5'd10, pack_exp(1'b0, 32'h3, 5'd10), 1'b0);
        send(3'b000, 32'h0000_00F0, 32'h0000_000F, 5'd11, pack_exp(1'b0, 32'hFF, 5'd11), 1'b0);
        bus.in_valid = 1'b0;
        chk("midrst_state_full", 64'(pipe_state), 64'(PIPE_FULL));
        rst = 1'b1;
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        chk_idle_outputs("midrst");
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("midrst_in_ready_after", bus.in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_no_output", bus.out_valid, 0);
        send(3'b010, 32'hFFFF_FFFF, 32'h8000_0001, 5'd12, pack_exp(1'b0, 32'h8000_0001, 5'd12), 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
